accumulator_bank: RTL and testbench
===================================

// Module: accumulator_bank
// PURPOSE
//  Multi-channel integrate-and-dump accumulator for the tracking channel correlators.
//  Each channel sums signed code x carrier products over one code period, one lane per
//  correlator arm (default E/P/L x I/Q). Saturates instead of wrapping and holds dumped
//  results until the processor acknowledges them.
//  Sits between the carrier/code mixers and the channel register/readout interface.
// PARAMETERS
//  NUM_CH  6   number of accumulator lanes (>=1)
//  ACC_W   16  accumulator/result width in bits, two's complement (>=4)
//  SAT_EN  1   1: clamp at the signed range limits; 0: wrap modulo 2^ACC_W (ovf still reported)
// PORTS
//  clk               in   1           sample clock (16.368 MHz)
//  rst               in   1           synchronous reset, active-high
//  sample_valid      in   1           inputs below carry a valid sample this cycle
//  code              in   NUM_CH      per-lane code chip: 0 => -1, 1 => +1
//  carrier_mix_sign  in   NUM_CH      per-lane carrier sign: 0 => negative, 1 => positive
//  carrier_mix_mag   in   3*NUM_CH    per-lane magnitude in {1,2,3,6}; lane k = [3k+2:3k]
//  dump_enable       in   1           end of integration period (shared by all lanes)
//  read_ack          in   1           processor has consumed the held results
//  accumulation      out  NUM_CH*ACC_W  latched per-lane results; lane k = [ACC_W*k +: ACC_W]
//  acc_ovf           out  NUM_CH      per-lane saturation/overflow flag for the latched period
//  dump_valid        out  1           held results are unread (level)
//  dump_overrun      out  1           sticky: a dump occurred while dump_valid was still set
// BEHAVIOUR
//  - All state updates on posedge clk. rst=1: internal acc, accumulation, acc_ovf,
//    dump_valid, dump_overrun all 0. rst has priority over every other input.
//  - Lane sample s_k = +mag_k if code_k == sign_k, else -mag_k. Magnitude is the 3-bit
//    unsigned value. Only the encodings 1,2,3,6 are legal; others are unchecked.
//  - Without dump_enable: if sample_valid, acc_k <= acc_k + s_k; otherwise acc_k holds.
//  - The sum is computed at ACC_W+1 bits. With SAT_EN=1, it clamps to
//    [-2^(ACC_W-1), 2^(ACC_W-1)-1]. With SAT_EN=0, it keeps the low ACC_W bits.
//    Each lane has an internal sticky ovf_k, set whenever the (ACC_W+1)-bit sum is out of range.
//  - dump_enable=1 (all lanes, same edge):
//    accumulation_k <= acc_k, acc_ovf_k <= ovf_k (the pre-dump value, excluding this cycle's sample).
//    If sample_valid: acc_k <= s_k. If not: acc_k <= 0. In both cases ovf_k <= 0.
//  - Dumped results and flags are visible the cycle after the dump edge, i.e. latency 1.
//    accumulation and acc_ovf hold until the next dump.
//  - Handshake on the same dump edge: dump_valid <= 1. If dump_valid was already 1 and
//    read_ack=0, dump_overrun <= 1 and the new results overwrite the held ones.
//    read_ack=1 with dump_valid=1 and no dump clears dump_valid.
//  - dump_enable and read_ack on the same edge: the dump wins. dump_valid stays 1 and no
//    overrun is flagged (the ack consumed the old data).
//  - dump_overrun clears only on rst. read_ack while dump_valid=0 is ignored.
//  - Reset mid-period discards the partial sums. The first period after reset starts from 0.
// TESTING
//  1) Lane 0 samples +1,-2,-3,+6,+2, then a dump with current sample -1 ->
//     accumulation[0]=4, dump_valid=1. Three more samples +3,-1,+6, then a dump ->
//     accumulation[0]=7.
//  2) All 6 lanes get distinct sequences (lane k: constant +k... as legal mags) over 10 samples, then a dump ->
//     each lane's result matches an independent model; the lanes do not interfere.
//  3) ACC_W=8, SAT_EN=1: 25 samples of +6, then a dump -> accumulation=127, acc_ovf=1.
//     Next period 3 samples of -6 -> -18, acc_ovf=0. Repeat with SAT_EN=0 -> 150 mod 256 = -106, acc_ovf=1.
//  4) sample_valid gaps: pattern +2,(gap),+3,(gap x3),-1, then a dump without sample_valid ->
//     result 4, and the next period starts at 0.
//  5) Handshake: two dumps with no read_ack -> dump_overrun=1 and the second result is held.
//     Dump coinciding with read_ack -> dump_valid stays 1, overrun unchanged. read_ack alone -> dump_valid=0.
//  6) rst asserted mid-period after +6,+6 -> all outputs 0. Then +1, dump -> result 1 (no residue).

Source files
------------

// File: rtl/accumulator_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : accumulator_bank_if
//  Brief    : Sample / dump / readout bundle between the carrier-code mixers,
//             the accumulator bank and the channel register interface.
//  Revision : 1.0  initial release
// ============================================================================
interface accumulator_bank_if #(
  parameter int NUM_CH = 6,
  parameter int ACC_W  = 16
);
  logic                      sample_valid;
  logic [NUM_CH-1:0]         code;
  logic [NUM_CH-1:0]         carrier_mix_sign;
  logic [3*NUM_CH-1:0]       carrier_mix_mag;
  logic                      dump_enable;
  logic                      read_ack;
  logic [NUM_CH*ACC_W-1:0]   accumulation;
  logic [NUM_CH-1:0]         acc_ovf;
  logic                      dump_valid;
  logic                      dump_overrun;

  // Mixer / processor side
  modport master (
    output sample_valid, code, carrier_mix_sign, carrier_mix_mag,
           dump_enable, read_ack,
    input  accumulation, acc_ovf, dump_valid, dump_overrun
  );

  // Accumulator bank side
  modport slave (
    input  sample_valid, code, carrier_mix_sign, carrier_mix_mag,
           dump_enable, read_ack,
    output accumulation, acc_ovf, dump_valid, dump_overrun
  );
endinterface
`default_nettype wire

// File: rtl/accumulator_bank.sv
`default_nettype none
// ============================================================================
//  Module   : accumulator_bank
//  Brief    : Multi-lane integrate-and-dump accumulator for the correlator
//             arms. Saturating (or wrapping) signed sums, per-lane overflow
//             flags, and a held-result handshake with overrun detection.
//  Revision : 1.0  initial release
// ============================================================================
module accumulator_bank #(
  parameter int NUM_CH = 6,
  parameter int ACC_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  accumulator_bank_if.slave  bus
);

  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Running sums and their sticky overflow flags for the current period
  logic [ACC_W-1:0]        r_acc [NUM_CH];
  logic [NUM_CH-1:0]       r_ovf;

  // Results latched at the last dump
  logic [NUM_CH*ACC_W-1:0] r_accumulation;
  logic [NUM_CH-1:0]       r_acc_ovf;
  logic                    r_dump_valid;
  logic                    r_dump_overrun;

  // Per-lane datapath, one bit wider than the accumulator so overflow is visible
  logic [ACC_W:0]          w_mag_ext [NUM_CH];
  logic [ACC_W:0]          w_sample  [NUM_CH];
  logic [ACC_W:0]          w_sum     [NUM_CH];
  logic [ACC_W-1:0]        w_next    [NUM_CH];
  logic [ACC_W-1:0]        w_seed    [NUM_CH];
  logic [NUM_CH-1:0]       w_oor;

  // Form the signed sample, the widened sum and the clamped/wrapped next value
  always_comb begin
    w_oor = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_mag_ext[k] = {{(ACC_W-2){1'b0}}, bus.carrier_mix_mag[3*k +: 3]};
      // Code chip and carrier sign agreeing means a positive product
      if (bus.code[k] == bus.carrier_mix_sign[k]) begin
        w_sample[k] = w_mag_ext[k];
      end else begin
        w_sample[k] = {(ACC_W+1){1'b0}} - w_mag_ext[k];
      end
      w_sum[k]  = {r_acc[k][ACC_W-1], r_acc[k]} + w_sample[k];
      // Top two bits disagree exactly when the sum leaves the ACC_W-bit range
      w_oor[k]  = w_sum[k][ACC_W] ^ w_sum[k][ACC_W-1];
      w_next[k] = w_sum[k][ACC_W-1:0];
      if (SAT_EN && w_oor[k]) begin
        w_next[k] = w_sum[k][ACC_W] ? c_ACC_MIN : c_ACC_MAX;
      end
      // A sample arriving on the dump edge opens the next period; magnitudes
      // are at most 7, so the low ACC_W bits hold it without loss
      w_seed[k] = bus.sample_valid ? w_sample[k][ACC_W-1:0] : '0;
    end
  end

  // Integrate samples, and on dump latch results and restart every lane
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k] <= '0;
      end
      r_ovf          <= '0;
      r_accumulation <= '0;
      r_acc_ovf      <= '0;
    end else if (bus.dump_enable) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_accumulation[ACC_W*k +: ACC_W] <= r_acc[k];
        r_acc[k]                         <= w_seed[k];
      end
      r_acc_ovf <= r_ovf;
      r_ovf     <= '0;
    end else if (bus.sample_valid) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc[k] <= w_next[k];
      end
      r_ovf <= r_ovf | w_oor;
    end
  end

  // Held-result handshake: a dump always wins over a simultaneous ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_valid   <= 1'b0;
      r_dump_overrun <= 1'b0;
    end else if (bus.dump_enable) begin
      r_dump_valid <= 1'b1;
      if (r_dump_valid && !bus.read_ack) begin
        r_dump_overrun <= 1'b1;
      end
    end else if (bus.read_ack) begin
      r_dump_valid <= 1'b0;
    end
  end

  assign bus.accumulation = r_accumulation;
  assign bus.acc_ovf      = r_acc_ovf;
  assign bus.dump_valid   = r_dump_valid;
  assign bus.dump_overrun = r_dump_overrun;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accumulator_bank
//  Brief    : Directed bench for accumulator_bank. Three instances share one
//             stimulus: 16-bit saturating, 8-bit saturating, 8-bit wrapping.
//             Expected dump results are queued when a dump is driven and
//             compared once the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accumulator_bank;

  localparam int NCH = 6;
  localparam int NDUT = 3;

  typedef struct {
    int d;
    int k;
    int acc;
    int ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic r_sample_valid;
  logic [NCH-1:0] r_code;
  logic [NCH-1:0] r_sign;
  logic [3*NCH-1:0] r_mag;
  logic r_dump;
  logic r_ack;

  accumulator_bank_if #(.NUM_CH(NCH), .ACC_W(16)) if0 ();
  accumulator_bank_if #(.NUM_CH(NCH), .ACC_W(8))  if1 ();
  accumulator_bank_if #(.NUM_CH(NCH), .ACC_W(8))  if2 ();

  assign if0.sample_valid = r_sample_valid;
  assign if0.code = r_code;
  assign if0.carrier_mix_sign = r_sign;
  assign if0.carrier_mix_mag = r_mag;
  assign if0.dump_enable = r_dump;
  assign if0.read_ack = r_ack;
  assign if1.sample_valid = r_sample_valid;
  assign if1.code = r_code;
  assign if1.carrier_mix_sign = r_sign;
  assign if1.carrier_mix_mag = r_mag;
  assign if1.dump_enable = r_dump;
  assign if1.read_ack = r_ack;
  assign if2.sample_valid = r_sample_valid;
  assign if2.code = r_code;
  assign if2.carrier_mix_sign = r_sign;
  assign if2.carrier_mix_mag = r_mag;
  assign if2.dump_enable = r_dump;
  assign if2.read_ack = r_ack;

  accumulator_bank #(.NUM_CH(NCH), .ACC_W(16), .SAT_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  accumulator_bank #(.NUM_CH(NCH), .ACC_W(8), .SAT_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));
  accumulator_bank #(.NUM_CH(NCH), .ACC_W(8), .SAT_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int s [NCH];
  int m_acc [NDUT][NCH];
  int m_ovf [NDUT][NCH];
  int m_dv = 0;
  int m_ov = 0;
  exp_t q [$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int lane_val(input int d, input int k);
    case (d)
      0:       lane_val = int'($signed(if0.accumulation[16*k +: 16]));
      1:       lane_val = int'($signed(if1.accumulation[8*k +: 8]));
      default: lane_val = int'($signed(if2.accumulation[8*k +: 8]));
    endcase
  endfunction

  function automatic int lane_ovf(input int d, input int k);
    case (d)
      0:       lane_ovf = int'(if0.acc_ovf[k]);
      1:       lane_ovf = int'(if1.acc_ovf[k]);
      default: lane_ovf = int'(if2.acc_ovf[k]);
    endcase
  endfunction

  function automatic int rnd_legal();
    int mags [4] = '{1, 2, 3, 6};
    int v;
    v = mags[$urandom_range(0, 3)];
    return ($urandom_range(0, 1) == 1) ? v : -v;
  endfunction

  task automatic set_all(input int v);
    for (int k = 0; k < NCH; k++) s[k] = v;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NCH; k++) s[k] = rnd_legal();
  endtask

  // One clock: drive s[] plus controls, advance the reference model, then check
  task automatic step(input bit rst_i, input bit sv, input bit dmp, input bit ack);
    int w, hi, lo, sum;
    bit sat;
    bit sg;
    exp_t e;
    for (int k = 0; k < NCH; k++) begin
      sg = 1'($urandom_range(0, 1));
      r_sign[k] = sg;
      r_code[k] = (s[k] > 0) ? sg : ~sg;
      r_mag[3*k +: 3] = 3'((s[k] < 0) ? -s[k] : s[k]);
    end
    rst = rst_i;
    r_sample_valid = sv;
    r_dump = dmp;
    r_ack = ack;
    for (int d = 0; d < NDUT; d++) begin
      w = (d == 0) ? 16 : 8;
      sat = (d != 2);
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      for (int k = 0; k < NCH; k++) begin
        if (rst_i) begin
          m_acc[d][k] = 0;
          m_ovf[d][k] = 0;
          e.d = d; e.k = k; e.acc = 0; e.ovf = 0;
          q.push_back(e);
        end else if (dmp) begin
          e.d = d; e.k = k; e.acc = m_acc[d][k]; e.ovf = m_ovf[d][k];
          q.push_back(e);
          m_acc[d][k] = sv ? s[k] : 0;
          m_ovf[d][k] = 0;
        end else if (sv) begin
          sum = m_acc[d][k] + s[k];
          if (sum > hi || sum < lo) begin
            m_ovf[d][k] = 1;
            if (sat) begin
              sum = (sum > hi) ? hi : lo;
            end else begin
              sum = sum & ((1 << w) - 1);
              if (sum > hi) sum = sum - (1 << w);
            end
          end
          m_acc[d][k] = sum;
        end
      end
    end
    if (rst_i) begin
      m_dv = 0;
      m_ov = 0;
    end else if (dmp) begin
      if (m_dv == 1 && !ack) m_ov = 1;
      m_dv = 1;
    end else if (ack) begin
      m_dv = 0;
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("acc_d%0d_l%0d", e.d, e.k), lane_val(e.d, e.k), e.acc);
      chk($sformatf("ovf_d%0d_l%0d", e.d, e.k), lane_ovf(e.d, e.k), e.ovf);
    end
    chk("dv_d0", int'(if0.dump_valid), m_dv);
    chk("ov_d0", int'(if0.dump_overrun), m_ov);
    chk("dv_d2", int'(if2.dump_valid), m_dv);
    chk("ov_d2", int'(if2.dump_overrun), m_ov);
    rst = 1'b0;
    r_dump = 1'b0;
    r_ack = 1'b0;
    r_sample_valid = 1'b0;
  endtask

  initial begin
    int seq1 [5] = '{1, -2, -3, 6, 2};
    int seq1b [3] = '{3, -1, 6};
    int lane_c [NCH] = '{1, 2, 3, 6, -1, -2};
    rst = 1'b1;
    r_sample_valid = 1'b0;
    r_code = '0;
    r_sign = '0;
    r_mag = '0;
    r_dump = 1'b0;
    r_ack = 1'b0;
    set_rand();

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);

    // Lane 0 directed sequence; a dump carrying a sample seeds the next period
    for (int i = 0; i < 5; i++) begin
      set_rand(); s[0] = seq1[i];
      step(0, 1, 0, 0);
    end
    set_rand(); s[0] = -1;
    step(0, 1, 1, 0);
    chk("t1_first_dump", lane_val(0, 0), 4);
    chk("t1_first_dv", int'(if0.dump_valid), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      set_rand(); s[0] = seq1b[i];
      step(0, 1, 0, 0);
    end
    set_rand();
    step(0, 0, 1, 0);
    chk("t1_second_dump", lane_val(0, 0), 7);
    step(0, 0, 0, 1);

    // Distinct constant per lane over 10 samples
    for (int k = 0; k < NCH; k++) s[k] = lane_c[k];
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t2_lane3", lane_val(0, 3), 60);
    chk("t2_lane5", lane_val(0, 5), -20);
    step(0, 0, 0, 1);

    // Saturation versus wrap at 8 bits
    set_all(6);
    for (int i = 0; i < 25; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t3_w16", lane_val(0, 0), 150);
    chk("t3_w16_ovf", lane_ovf(0, 0), 0);
    chk("t3_sat", lane_val(1, 0), 127);
    chk("t3_sat_ovf", lane_ovf(1, 0), 1);
    chk("t3_wrap", lane_val(2, 0), -106);
    chk("t3_wrap_ovf", lane_ovf(2, 0), 1);
    step(0, 0, 0, 1);
    set_all(-6);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t3_neg_sat", lane_val(1, 2), -18);
    chk("t3_neg_sat_ovf", lane_ovf(1, 2), 0);
    chk("t3_neg_wrap", lane_val(2, 2), -18);
    chk("t3_neg_wrap_ovf", lane_ovf(2, 2), 0);
    step(0, 0, 0, 1);

    // sample_valid gaps
    set_all(2); step(0, 1, 0, 0);
    set_rand(); step(0, 0, 0, 0);
    set_all(3); step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      set_rand(); step(0, 0, 0, 0);
    end
    set_all(-1); step(0, 1, 0, 0);
    set_rand(); step(0, 0, 1, 0);
    chk("t4_gaps", lane_val(0, 1), 4);
    set_rand(); step(0, 0, 1, 1);
    chk("t4_restart", lane_val(0, 1), 0);
    step(0, 0, 0, 1);

    // Handshake: dump+ack, ack alone, ignored ack, then overrun
    set_rand(); step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    set_rand(); step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    chk("t5_dump_ack_dv", int'(if0.dump_valid), 1);
    chk("t5_dump_ack_ov", int'(if0.dump_overrun), 0);
    step(0, 0, 0, 1);
    chk("t5_ack_dv", int'(if0.dump_valid), 0);
    step(0, 0, 0, 1);
    set_rand(); step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    set_rand(); step(0, 1, 0, 0);
    set_rand(); step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("t5_overrun", int'(if0.dump_overrun), 1);
    step(0, 0, 0, 1);
    chk("t5_overrun_sticky", int'(if0.dump_overrun), 1);

    // Reset mid-period discards partial sums
    set_all(6);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    set_rand(); step(1, 1, 0, 0);
    chk("t6_rst_ov", int'(if1.dump_overrun), 0);
    set_all(1); step(0, 1, 0, 0);
    set_rand(); step(0, 0, 1, 0);
    chk("t6_no_residue", lane_val(0, 4), 1);
    chk("t6_no_residue_w8", lane_val(1, 4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
